pipe_hazard_ctrl: RTL and testbench
===================================

PIPE_HAZARD_CTRL -- requirements
Module: pipe_hazard_ctrl

Interface
REQ-001 Parameter MDU_CYCLES, default 4: ID stall cycles per multi-cycle mul/div op; legal range 1..255.
REQ-002 Parameter DELAY_SLOT, default 0: 1 means branch delay slot, so no IF/ID flush on a taken branch or jump.
REQ-003 clk  input  1  single clock; all state updates on the rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 id_rs, id_rt  input  5 each  source register numbers of the instruction in ID.
REQ-006 id_use_rs, id_use_rt  input  1 each  the ID instruction reads rs / rt.
REQ-007 ex_wreg, ex_m2reg  input  1 each  the EX instruction writes a register / is a load.
REQ-008 ex_rd  input  5  destination register of the EX instruction.
REQ-009 id_taken  input  1  branch taken or jump resolved in ID this cycle.
REQ-010 id_mdu  input  1  the ID instruction is a multi-cycle mul/div.
REQ-011 wpcir  output  1  write enable for the PC and the IF/ID register (0 = hold).
REQ-012 reset_ir  output  1  IF/ID flush (loads zero / NOP).
REQ-013 id_bubble  output  1  force a NOP into ID/EX.
REQ-014 mdu_busy  output  1  multi-cycle unit occupied.

Function
REQ-015 The block SHALL have states RUN and MDU_BUSY, plus an 8-bit down-counter cnt.
REQ-016 Load-use condition lu SHALL be: ex_wreg & ex_m2reg & (ex_rd!=0) & ((id_use_rs & id_rs==ex_rd) | (id_use_rt & id_rt==ex_rd)).
REQ-017 In RUN with lu=1, the block SHALL combinationally drive wpcir=0, id_bubble=1 and reset_ir=0 in the same cycle, regardless of id_taken or id_mdu.
REQ-018 In RUN with lu=0, id_taken=1 and DELAY_SLOT=0, the block SHALL drive wpcir=1 and reset_ir=1 for exactly that cycle.
REQ-019 In RUN with lu=0 and id_mdu=1, the block SHALL let the instruction advance (wpcir=1), load cnt=MDU_CYCLES-1 and enter MDU_BUSY at the next edge.
REQ-020 When id_mdu and id_taken are both 1 in RUN with lu=0, the block SHALL apply both rules.
REQ-021 In MDU_BUSY, the block SHALL drive wpcir=0, id_bubble=1, reset_ir=0 and mdu_busy=1, ignoring id_taken, id_mdu and lu.
REQ-022 In MDU_BUSY, cnt SHALL decrement each cycle; when cnt==0 the state SHALL return to RUN at the next edge.
REQ-023 MDU_BUSY SHALL therefore last exactly MDU_CYCLES cycles.
REQ-024 In RUN with no hazard, the outputs SHALL be wpcir=1, reset_ir=0, id_bubble=0 and mdu_busy=0.
REQ-025 The outputs SHALL be a combinational function of the state and the current inputs; there is no extra latency.

Reset
REQ-026 While reset=1 (asynchronously), the state SHALL be RUN, cnt=0, and the outputs SHALL be wpcir=1, reset_ir=0, id_bubble=0 and mdu_busy=0.
REQ-027 Reset asserted during MDU_BUSY SHALL abort the stall immediately; after release the block is in RUN.

Configuration
REQ-028 With HAZARD_STATS_EN defined, the block SHALL add output stall_cnt[31:0], which increments each cycle wpcir=0.
REQ-029 With HAZARD_STATS_EN defined, the block SHALL add output flush_cnt[31:0], which increments each cycle reset_ir=1.
REQ-030 Both counters SHALL wrap modulo 2^32 and clear to 0 on reset.
REQ-031 Without HAZARD_STATS_EN, the counters and their ports SHALL be absent, and the remaining behaviour is identical.

Verification
REQ-032 Load-use case: ex_m2reg=1, ex_wreg=1, ex_rd=5, id_rs=5, id_use_rs=1 -> same cycle wpcir=0, id_bubble=1; next cycle with ex_m2reg=0 -> wpcir=1.
REQ-033 ex_rd=0 with otherwise matching load-use inputs -> no stall (wpcir=1).
REQ-034 id_taken=1 with DELAY_SLOT=0 -> reset_ir=1 for one cycle; the same stimulus with DELAY_SLOT=1 -> reset_ir=0.
REQ-035 id_mdu=1 with MDU_CYCLES=4 -> mdu_busy=1 and wpcir=0 for exactly 4 cycles, then wpcir=1; with MDU_CYCLES=1 -> exactly 1 stall cycle.
REQ-036 lu=1 and id_taken=1 together -> wpcir=0, reset_ir=0; next cycle with lu=0 -> reset_ir=1.
REQ-037 Reset pulsed in the 2nd MDU_BUSY cycle -> the outputs return to the REQ-026 values immediately.
REQ-038 Under HAZARD_STATS_EN, the REQ-035 MDU_CYCLES=4 run -> stall_cnt=4.

Source files
------------

// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl: load-use stall, branch flush and multi-cycle MDU stall control for a 5-stage pipe.
// Optional HAZARD_STATS_EN adds free-running stall_cnt / flush_cnt outputs.
module pipe_hazard_ctrl #(
  parameter int MDU_CYCLES = 4,
  parameter int DELAY_SLOT = 0
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [4:0] id_rs,
  input  logic [4:0] id_rt,
  input  logic       id_use_rs,
  input  logic       id_use_rt,
  input  logic       ex_wreg,
  input  logic       ex_m2reg,
  input  logic [4:0] ex_rd,
  input  logic       id_taken,
  input  logic       id_mdu,
  output logic       wpcir,
  output logic       reset_ir,
  output logic       id_bubble,
  output logic       mdu_busy
`ifdef HAZARD_STATS_EN
  ,
  output logic [31:0] stall_cnt,
  output logic [31:0] flush_cnt
`endif
);
  typedef enum logic {RUN, MDU_BUSY} state_t;
  state_t     state, state_nx;
  logic [7:0] cnt, cnt_nx;
  logic       lu, busy;
  assign lu = ex_wreg && ex_m2reg && (ex_rd != 5'd0) &&
              ((id_use_rs && id_rs == ex_rd) || (id_use_rt && id_rt == ex_rd));
  assign busy = state == MDU_BUSY;
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state <= RUN;
      cnt   <= '0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
    end
  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    if (busy) begin
      state_nx = cnt == 8'd0 ? RUN : MDU_BUSY;
      cnt_nx   = cnt == 8'd0 ? cnt : cnt - 8'd1;
    end else if (!lu && id_mdu) begin
      state_nx = MDU_BUSY;
      cnt_nx   = 8'(MDU_CYCLES - 1);
    end
  end
  // reset masks lu so the outputs sit at their idle values while reset is high
  always_comb begin
    wpcir     = reset || (!busy && !lu);
    id_bubble = !reset && (busy || lu);
    reset_ir  = !reset && !busy && !lu && id_taken && (DELAY_SLOT == 0);
    mdu_busy  = !reset && busy;
  end
`ifdef HAZARD_STATS_EN
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      stall_cnt <= wpcir ? stall_cnt : stall_cnt + 32'd1;
      flush_cnt <= reset_ir ? flush_cnt + 32'd1 : flush_cnt;
    end
`endif
endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// tb_pipe_hazard_ctrl: directed + random checks of two pipe_hazard_ctrl configurations
// (MDU_CYCLES=4/DELAY_SLOT=0 and MDU_CYCLES=1/DELAY_SLOT=1) against a remaining-stall-cycles model.
module tb_pipe_hazard_ctrl;
  logic clk = 1'b0, reset = 1'b1;
  logic [4:0] id_rs = '0, id_rt = '0, ex_rd = '0;
  logic id_use_rs = 0, id_use_rt = 0, ex_wreg = 0, ex_m2reg = 0, id_taken = 0, id_mdu = 0;
  logic w[2], r[2], b[2], m[2];
  logic [31:0] sc_dut[2], fc_dut[2];
  int checks = 0, failures = 0;
  int rem[2];
  int mc[2] = '{4, 1};
  bit ds[2] = '{0, 1};
  logic [31:0] sc[2], fc[2];

  always #5 clk = ~clk;

  pipe_hazard_ctrl #(.MDU_CYCLES(4), .DELAY_SLOT(0)) dut_a (
    .clk(clk), .reset(reset), .id_rs(id_rs), .id_rt(id_rt), .id_use_rs(id_use_rs),
    .id_use_rt(id_use_rt), .ex_wreg(ex_wreg), .ex_m2reg(ex_m2reg), .ex_rd(ex_rd),
    .id_taken(id_taken), .id_mdu(id_mdu), .wpcir(w[0]), .reset_ir(r[0]),
    .id_bubble(b[0]), .mdu_busy(m[0])
`ifdef HAZARD_STATS_EN
    , .stall_cnt(sc_dut[0]), .flush_cnt(fc_dut[0])
`endif
  );
  pipe_hazard_ctrl #(.MDU_CYCLES(1), .DELAY_SLOT(1)) dut_b (
    .clk(clk), .reset(reset), .id_rs(id_rs), .id_rt(id_rt), .id_use_rs(id_use_rs),
    .id_use_rt(id_use_rt), .ex_wreg(ex_wreg), .ex_m2reg(ex_m2reg), .ex_rd(ex_rd),
    .id_taken(id_taken), .id_mdu(id_mdu), .wpcir(w[1]), .reset_ir(r[1]),
    .id_bubble(b[1]), .mdu_busy(m[1])
`ifdef HAZARD_STATS_EN
    , .stall_cnt(sc_dut[1]), .flush_cnt(fc_dut[1])
`endif
  );

  function automatic bit load_use();
    return ex_wreg && ex_m2reg && ex_rd != 0 &&
           ((id_use_rs && id_rs == ex_rd) || (id_use_rt && id_rt == ex_rd));
  endfunction

  function automatic bit exp_stall(int k);
    return !reset && (rem[k] > 0 || load_use());
  endfunction

  function automatic bit exp_flush(int k);
    return !reset && rem[k] == 0 && !load_use() && id_taken && !ds[k];
  endfunction

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all(string tag);
    for (int k = 0; k < 2; k++) begin
      chk($sformatf("%s.%0d.wpcir", tag, k), 32'(w[k]), 32'(!exp_stall(k)));
      chk($sformatf("%s.%0d.id_bubble", tag, k), 32'(b[k]), 32'(exp_stall(k)));
      chk($sformatf("%s.%0d.reset_ir", tag, k), 32'(r[k]), 32'(exp_flush(k)));
      chk($sformatf("%s.%0d.mdu_busy", tag, k), 32'(m[k]), 32'(!reset && rem[k] > 0));
`ifdef HAZARD_STATS_EN
      chk($sformatf("%s.%0d.stall_cnt", tag, k), sc_dut[k], sc[k]);
      chk($sformatf("%s.%0d.flush_cnt", tag, k), fc_dut[k], fc[k]);
`endif
    end
  endtask

  // called just after a rising edge; inputs still hold the values the DUT sampled
  task automatic advance();
    for (int k = 0; k < 2; k++) begin
      if (reset) begin
        rem[k] = 0; sc[k] = 0; fc[k] = 0;
      end else begin
        if (exp_stall(k)) sc[k]++;
        if (exp_flush(k)) fc[k]++;
        if (rem[k] > 0) rem[k]--;
        else if (!load_use() && id_mdu) rem[k] = mc[k];
      end
    end
  endtask

  task automatic step(string tag);
    #2;
    check_all(tag);
    @(posedge clk);
    advance();
    @(negedge clk);
  endtask

  task automatic idle();
    id_rs = 0; id_rt = 0; ex_rd = 0; id_use_rs = 0; id_use_rt = 0;
    ex_wreg = 0; ex_m2reg = 0; id_taken = 0; id_mdu = 0;
  endtask

  task automatic set_lu(logic [4:0] rd);
    ex_wreg = 1; ex_m2reg = 1; ex_rd = rd; id_rs = 5; id_use_rs = 1;
  endtask

  initial begin
    for (int k = 0; k < 2; k++) begin rem[k] = 0; sc[k] = 0; fc[k] = 0; end
    #1 check_all("reset");
    @(posedge clk); advance(); @(negedge clk);
    reset = 0;
    step("idle");
    set_lu(5); step("lu_stall");
    ex_m2reg = 0; step("lu_release");
    idle(); set_lu(0); step("rd_zero");
    idle(); id_use_rt = 1; id_rt = 7; ex_wreg = 1; ex_m2reg = 1; ex_rd = 7; step("lu_rt");
    idle(); id_taken = 1; step("taken");
    id_taken = 0; step("after_taken");
    id_mdu = 1; step("mdu_start");
    id_mdu = 0;
    for (int i = 0; i < 5; i++) step($sformatf("mdu_busy%0d", i));
    set_lu(5); id_taken = 1; step("lu_and_taken");
    ex_m2reg = 0; step("taken_after_lu");
    idle(); id_mdu = 1; id_taken = 1; step("mdu_and_taken");
    idle(); step("mdu_taken_busy");
    set_lu(5); id_mdu = 1; step("lu_blocks_mdu");
    idle(); step("no_mdu_after_lu");
    id_mdu = 1; step("mdu_start2");
    idle(); step("busy_cycle1");
    #1 reset = 1;
    for (int k = 0; k < 2; k++) begin rem[k] = 0; sc[k] = 0; fc[k] = 0; end
    set_lu(5); id_taken = 1;
    #1 check_all("rst_abort");
    @(posedge clk); advance(); @(negedge clk);
    reset = 0; idle();
    step("after_rst");
    for (int i = 0; i < 400; i++) begin
      ex_rd = 5'($urandom_range(0, 3));
      id_rs = 5'($urandom_range(0, 3));
      id_rt = 5'($urandom_range(0, 3));
      {id_use_rs, id_use_rt, ex_wreg, ex_m2reg} = 4'($urandom);
      id_taken = ($urandom_range(0, 3) == 0);
      id_mdu = ($urandom_range(0, 7) == 0);
      reset = ($urandom_range(0, 99) == 0);
      if (reset) for (int k = 0; k < 2; k++) begin rem[k] = 0; sc[k] = 0; fc[k] = 0; end
      step("rand");
      reset = 0;
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
